// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall controller for the 5-stage pipeline. Decodes read-after-write hazards
// between the D-stage sources (rs, rt) and the E/M destinations using the
// Tuse/Tnew scheme. It also tracks the busy window of the HI/LO
// multiply/divide unit. A single stall term drives the F/D freeze, the PC
// enable and the D/E bubble.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   rs_d, rt_d            D-stage source register indices
//   tuse_rs_d, tuse_rt_d  cycles until D needs the source (3 = never read)
//   md_use_d              D instruction uses the mult/div unit or HI/LO
//   a_e, tnew_e           E-stage destination (0 = none) and its Tnew
//   a_m, tnew_m           M-stage destination (0 = none) and its Tnew
//   start_e, is_div_e     mult/div launches in E; 1 = divide, 0 = multiply
//   freeze_fd             hold the F/D register
//   pc_en                 PC update enable
//   flush_de              clear the D/E register (insert a nop)
//   md_busy               mult/div unit busy (state register decode)
//   stall_cnt             saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [1:0]  tuse_rs_d,
  input  logic [1:0]  tuse_rt_d,
  input  logic        md_use_d,
  input  logic [4:0]  a_e,
  input  logic [1:0]  tnew_e,
  input  logic [4:0]  a_m,
  input  logic [1:0]  tnew_m,
  input  logic        start_e,
  input  logic        is_div_e,
  output logic        freeze_fd,
  output logic        pc_en,
  output logic        flush_de,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;

  // Source 0 is rs, source 1 is rt.
  logic [1:0][4:0]   src;
  logic [1:0][1:0]   tuse;
  logic [1:0]        hit_e;
  logic [1:0]        hit_m;
  logic              md_stall;
  logic              stall;

  assign src[0]  = rs_d;
  assign src[1]  = rt_d;
  assign tuse[0] = tuse_rs_d;
  assign tuse[1] = tuse_rt_d;

  // A producer only forces a stall when its result arrives later than the
  // consumer needs it. Register $0 is hard-wired, so it is never a hazard.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit_e[gi] = (src[gi] != 5'd0) && (src[gi] == a_e) &&
                         (tuse[gi] < tnew_e);
      assign hit_m[gi] = (src[gi] != 5'd0) && (src[gi] == a_m) &&
                         (tuse[gi] < tnew_m);
    end
  endgenerate

  assign md_busy  = (state_reg == BUSY);

  // start_e is included so that an HI/LO consumer directly behind the
  // launching mult/div stalls in the launch cycle, before md_busy rises.
  assign md_stall = md_use_d && (md_busy || start_e);

  // One OR-reduced term feeds all three controls, so they always agree.
  // A data hazard that overlaps an md stall still counts once.
  assign stall     = (|hit_e) || (|hit_m) || md_stall;
  assign freeze_fd = stall;
  assign pc_en     = ~stall;
  assign flush_de  = stall;

  // Mult/div busy tracker: next state and count.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (start_e) begin
          cnt_next   = is_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A start_e seen here is illegal and is deliberately ignored. The
        // running count is not reloaded.
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Performance counter. It holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
